series_sum_engine: RTL and testbench

Parametrised, multi-mode successor to the natural-number sum datapath. It accepts a count N and a series mode through a valid/ready handshake and accumulates one series term per clock. It returns the sum over k = 1..N through a valid/ready output handshake, with a sticky overflow flag. It sits between the N producer and the result consumer and replaces the fixed 8-bit/18-bit natural-sum-only datapath.

---
 rtl/series_sum_pkg.sv | 24 ++
 rtl/series_term_gen.sv | 57 +++++
 rtl/series_sum_engine.sv | 122 ++++++++++++
 tb/tb_series_sum_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/series_sum_pkg.sv
// rtl/series_sum_pkg.sv - shared types and constants for the series sum engine
package series_sum_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SER_NAT  = 2'd0,
    SER_ODD  = 2'd1,
    SER_EVEN = 2'd2,
    SER_SQR  = 2'd3
  } ser_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Value of term(1) for each series; every series starts at 1 except even (2).
  function automatic logic [1:0] first_term(input ser_mode_e mode);
    return (mode == SER_EVEN) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/series_term_gen.sv
// rtl/series_term_gen.sv - incremental multiplier-free series term generator
module series_term_gen
  import series_sum_pkg::*;
#(
  parameter int N_WIDTH = 8,
  localparam int TERM_W = 2 * N_WIDTH + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [TERM_W-1:0] term_o
);

  ser_mode_e          mode_q, mode_d;
  logic [TERM_W-1:0]  term_q, term_d;
  // Square steps add 2k+1; delta_q holds that odd increment for the current k.
  logic [TERM_W-1:0]  delta_q, delta_d;

  always_comb begin
    mode_d  = mode_q;
    term_d  = term_q;
    delta_d = delta_q;
    if (load_i) begin
      mode_d  = ser_mode_e'(mode_i);
      term_d  = TERM_W'(first_term(ser_mode_e'(mode_i)));
      delta_d = TERM_W'(3);
    end else if (step_i) begin
      case (mode_q)
        SER_NAT:  term_d = term_q + TERM_W'(1);
        SER_ODD,
        SER_EVEN: term_d = term_q + TERM_W'(2);
        SER_SQR: begin
          term_d  = term_q + delta_q;
          delta_d = delta_q + TERM_W'(2);
        end
        default:  term_d = term_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q  <= SER_NAT;
      term_q  <= '0;
      delta_q <= '0;
    end else begin
      mode_q  <= mode_d;
      term_q  <= term_d;
      delta_q <= delta_d;
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/series_sum_engine.sv
// rtl/series_sum_engine.sv - handshaked engine summing k=1..N of a selectable series
module series_sum_engine
  import series_sum_pkg::*;
#(
  parameter int N_WIDTH   = 8,
  parameter int SUM_WIDTH = 3 * N_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [N_WIDTH-1:0]   N,
  input  logic [MODE_W-1:0]    Mode,
  input  logic                 N_valid,
  output logic                 N_ready,
  output logic [SUM_WIDTH-1:0] Sum_out,
  output logic                 Sum_ovf,
  output logic                 Sum_valid,
  input  logic                 Sum_ready
);

  localparam int TERM_W = 2 * N_WIDTH + 1;
  localparam int ADD_W  = ((SUM_WIDTH > TERM_W) ? SUM_WIDTH : TERM_W) + 1;

  state_e               state_q, state_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic [N_WIDTH:0]     k_q, k_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  logic                 gen_load;
  logic                 gen_step;
  logic [TERM_W-1:0]    term;
  logic [ADD_W-1:0]     sum_wide;
  logic                 wrap;

  series_term_gen #(
    .N_WIDTH (N_WIDTH)
  ) u_term_gen (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .load_i (gen_load),
    .step_i (gen_step),
    .mode_i (Mode),
    .term_o (term)
  );

  // Wide add so a carry beyond SUM_WIDTH is seen even when the term alone exceeds it.
  assign sum_wide = ADD_W'(acc_q) + ADD_W'(term);
  assign wrap     = |sum_wide[ADD_W-1:SUM_WIDTH];

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (N_valid) begin
          gen_load = 1'b1;
          n_d      = N;
          acc_d    = '0;
          ovf_d    = 1'b0;
          k_d      = (N_WIDTH + 1)'(1);
          if (N == '0) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        gen_step = 1'b1;
        acc_d    = sum_wide[SUM_WIDTH-1:0];
        ovf_d    = ovf_q | wrap;
        k_d      = k_q + (N_WIDTH + 1)'(1);
        if (k_q == {1'b0, n_q}) begin
          state_d = S_DONE;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (Sum_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign N_ready   = (state_q == S_IDLE);
  assign Sum_out   = acc_q;
  assign Sum_ovf   = ovf_q;
  assign Sum_valid = valid_q;

endmodule

// File: tb/tb_series_sum_engine.sv
// tb/tb_series_sum_engine.sv - directed self-checking bench for series_sum_engine
module tb_series_sum_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  n;
  logic [1:0]  mode;
  logic        n_valid;
  logic        sum_ready;

  logic        n_ready, sum_ovf, sum_valid;
  logic [23:0] sum_out;
  logic        n_ready8, sum_ovf8, sum_valid8;
  logic [7:0]  sum_out8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  series_sum_engine dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .N         (n),
    .Mode      (mode),
    .N_valid   (n_valid),
    .N_ready   (n_ready),
    .Sum_out   (sum_out),
    .Sum_ovf   (sum_ovf),
    .Sum_valid (sum_valid),
    .Sum_ready (sum_ready)
  );

  series_sum_engine #(.N_WIDTH(8), .SUM_WIDTH(8)) dut8 (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .N         (n),
    .Mode      (mode),
    .N_valid   (n_valid),
    .N_ready   (n_ready8),
    .Sum_out   (sum_out8),
    .Sum_ovf   (sum_ovf8),
    .Sum_valid (sum_valid8),
    .Sum_ready (sum_ready)
  );

  task automatic start_job(input logic [7:0] nn, input logic [1:0] mm);
    n       = nn;
    mode    = mm;
    n_valid = 1'b1;
    @(posedge clk);
    #1;
    n_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!sum_valid && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; n = '0; mode = '0; n_valid = 1'b0; sum_ready = 1'b0;
    #12;
    checks++;
    if (n_ready !== 1'b1 || sum_valid !== 1'b0 || sum_out !== 24'd0 || sum_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b sum=%0d ovf=%b required 1 0 0 0",
               n_ready, sum_valid, sum_out, sum_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_natural;
    int lat;
    sum_ready = 1'b1;
    start_job(8'd10, 2'd0);
    n = 8'd5;
    wait_valid(lat);
    checks++;
    if (lat !== 10 || sum_out !== 24'd55 || sum_ovf !== 1'b0) begin
      errors++;
      $display("FAIL natural_10: lat=%0d sum=%0d ovf=%b required 10 55 0", lat, sum_out, sum_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (sum_valid !== 1'b0 || n_ready !== 1'b1) begin
      errors++;
      $display("FAIL natural_one_cycle: valid=%b ready=%b required 0 1", sum_valid, n_ready);
    end
  endtask

  task automatic test_modes;
    logic [7:0]  tn[3]   = '{8'd5, 8'd5, 8'd10};
    logic [1:0]  tm[3]   = '{2'd1, 2'd2, 2'd3};
    logic [23:0] texp[3] = '{24'd25, 24'd30, 24'd385};
    int lat;
    sum_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_job(tn[i], tm[i]);
      wait_valid(lat);
      checks++;
      if (lat !== int'(tn[i]) || sum_out !== texp[i] || sum_ovf !== 1'b0) begin
        errors++;
        $display("FAIL mode_%0d: lat=%0d sum=%0d ovf=%b required %0d %0d 0",
                 tm[i], lat, sum_out, sum_ovf, tn[i], texp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero;
    sum_ready = 1'b0;
    start_job(8'd0, 2'd2);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 24'd0 || n_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_n: valid=%b sum=%0d ready=%b required 1 0 0", sum_valid, sum_out, n_ready);
    end
    sum_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum_valid !== 1'b0 || n_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_release: valid=%b ready=%b required 0 1", sum_valid, n_ready);
    end
  endtask

  task automatic test_max_and_wrap;
    int lat;
    sum_ready = 1'b1;
    start_job(8'd255, 2'd3);
    wait_valid(lat);
    checks++;
    if (lat !== 255 || sum_out !== 24'd5559680 || sum_ovf !== 1'b0) begin
      errors++;
      $display("FAIL square_255: lat=%0d sum=%0d ovf=%b required 255 5559680 0", lat, sum_out, sum_ovf);
    end
    @(posedge clk); #1;
    start_job(8'd255, 2'd0);
    wait_valid(lat);
    checks++;
    if (sum_valid8 !== 1'b1 || sum_out8 !== 8'd128 || sum_ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL wrap8_255: valid=%b sum=%0d ovf=%b required 1 128 1", sum_valid8, sum_out8, sum_ovf8);
    end
    checks++;
    if (sum_out !== 24'd32640 || sum_ovf !== 1'b0) begin
      errors++;
      $display("FAIL natural_255: sum=%0d ovf=%b required 32640 0", sum_out, sum_ovf);
    end
    @(posedge clk); #1;
    start_job(8'd3, 2'd0);
    wait_valid(lat);
    checks++;
    if (lat !== 3 || sum_out8 !== 8'd6 || sum_ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap8_clear: lat=%0d sum=%0d ovf=%b required 3 6 0", lat, sum_out8, sum_ovf8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    sum_ready = 1'b0;
    start_job(8'd3, 2'd0);
    wait_valid(lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      n_valid = ~n_valid;
      n = 8'd7;
      @(posedge clk); #1;
      checks++;
      if (sum_valid !== 1'b1 || sum_out !== 24'd6 || n_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b sum=%0d ready=%b required 1 6 0",
                 i, sum_valid, sum_out, n_ready);
      end
    end
    n_valid = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum_valid !== 1'b0 || n_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", sum_valid, n_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    sum_ready = 1'b1;
    start_job(8'd2, 2'd2);
    wait_valid(lat);
    n = 8'd3; mode = 2'd0; n_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (n_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_queue: ready=%b required 1", n_ready);
    end
    @(posedge clk); #1;
    n_valid = 1'b0;
    checks++;
    if (n_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b required 0", n_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 3 || sum_out !== 24'd6) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d sum=%0d required 3 6", lat, sum_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    int lat;
    sum_ready = 1'b1;
    start_job(8'd10, 2'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (n_ready !== 1'b1 || sum_valid !== 1'b0 || sum_out !== 24'd0 || sum_ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b valid=%b sum=%0d ovf=%b required 1 0 0 0",
               n_ready, sum_valid, sum_out, sum_ovf);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    start_job(8'd4, 2'd0);
    wait_valid(lat);
    checks++;
    if (lat !== 4 || sum_out !== 24'd10 || sum_ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_job: lat=%0d sum=%0d ovf=%b required 4 10 0", lat, sum_out, sum_ovf);
    end
  endtask

  initial begin
    test_reset;
    test_natural;
    test_modes;
    test_zero;
    test_max_and_wrap;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
